// File: rtl/silife_pkg.sv
// Shared types and rule for the Game-of-Life grid controller.
// Holds the controller state enum, neighbour-count width and life rule.
package silife_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALTED
    } state_t;

    localparam int CNT_W = 4;

    function automatic logic life_rule(
        input logic             alive,
        input logic [CNT_W-1:0] n
    );
        return (n == CNT_W'(3)) || (alive && (n == CNT_W'(2)));
    endfunction

endpackage

// File: rtl/silife_cell.sv
// One Game-of-Life cell: state register, 8-neighbour count and rule.
// Ports: clk, rst, en (evolve), set/clr (write), nbr[8] in;
//        alive (current), nxt (post-edge value), changed (evolution flipped it).
module silife_cell
    import silife_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set,
    input  logic       clr,
    input  logic [7:0] nbr,
    output logic       alive,
    output logic       nxt,
    output logic       changed
);

    logic [CNT_W-1:0] cnt;
    logic             evo;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + CNT_W'(nbr[i]);
        end
    end

    assign evo = life_rule(alive, cnt);

    // A write wins over evolution for this cell.
    always_comb begin
        nxt = alive;
        if (set) begin
            nxt = 1'b1;
        end else if (clr) begin
            nxt = 1'b0;
        end else if (en) begin
            nxt = evo;
        end
    end

    // Written cells never count as changed by evolution.
    assign changed = en & ~set & ~clr & (evo ^ alive);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive <= 1'b0;
        end else begin
            alive <= nxt;
        end
    end

endmodule

// File: rtl/silife_grid_ctrl.sv
// WIDTH x HEIGHT Game-of-Life array with run/step/halt controller.
// Ports: clk, reset, run, step, wrap_mode, halt_on_still, wr_en/wr_row/
//   wr_data, rd_row in; rd_data, generation, still, extinct, busy, halted out.
module silife_grid_ctrl
    import silife_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int GEN_WIDTH = 16,
    parameter int ROW_BITS  = $clog2(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 wrap_mode,
    input  logic                 halt_on_still,
    input  logic                 wr_en,
    input  logic [ROW_BITS-1:0]  wr_row,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ROW_BITS-1:0]  rd_row,
    output logic [WIDTH-1:0]     rd_data,
    output logic [GEN_WIDTH-1:0] generation,
    output logic                 still,
    output logic                 extinct,
    output logic                 busy,
    output logic                 halted
);

    localparam int N = WIDTH * HEIGHT;

    state_t             state;
    state_t             state_nxt;
    logic               evolve;
    logic               any_chg;
    logic [N-1:0]       cells;
    logic [N-1:0]       cells_nxt;
    logic [N-1:0]       chg;
    logic [HEIGHT-1:0]  wr_hit;
    logic [WIDTH-1:0]   rd_mux;

    assign evolve  = (state == RUN) || (state == STEP);
    assign any_chg = |chg;
    assign busy    = evolve;
    assign halted  = (state == HALTED);

    // Out-of-range rows never match, so such writes drop and reads give 0.
    always_comb begin
        wr_hit = '0;
        rd_mux = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            wr_hit[r] = wr_en && (wr_row == ROW_BITS'(r));
            if (rd_row == ROW_BITS'(r)) begin
                rd_mux = cells[r*WIDTH +: WIDTH];
            end
        end
    end

    // Cell (r,c) lives at cells[r*WIDTH+c]; bit WIDTH-1 is west, row 0 north.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [7:0] nbr;

            for (genvar k = 0; k < 9; k++) begin : g_nb
                if (k != 4) begin : g_use
                    localparam int RR   = r + k / 3 - 1;
                    localparam int CC   = c + k % 3 - 1;
                    localparam bit EDGE = (RR < 0) || (RR >= HEIGHT) ||
                                          (CC < 0) || (CC >= WIDTH);
                    localparam int RW   = (RR + HEIGHT) % HEIGHT;
                    localparam int CW   = (CC + WIDTH) % WIDTH;
                    localparam int IDX  = (k < 4) ? k : k - 1;
                    // Off-grid neighbours are dead unless wrapping.
                    assign nbr[IDX] = cells[RW*WIDTH+CW] &
                                      (wrap_mode | ~EDGE);
                end
            end

            silife_cell u_cell (
                .clk     (clk),
                .rst     (reset),
                .en      (evolve),
                .set     (wr_hit[r] & wr_data[c]),
                .clr     (wr_hit[r] & ~wr_data[c]),
                .nbr     (nbr),
                .alive   (cells[r*WIDTH+c]),
                .nxt     (cells_nxt[r*WIDTH+c]),
                .changed (chg[r*WIDTH+c])
            );
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (halt_on_still && !any_chg) begin
                    state_nxt = HALTED;
                end
            end
            STEP: begin
                state_nxt = IDLE;
            end
            HALTED: begin
                if (!run) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            generation <= '0;
            still      <= 1'b0;
            extinct    <= 1'b1;
            rd_data    <= '0;
        end else begin
            state   <= state_nxt;
            rd_data <= rd_mux;
            extinct <= ~|cells_nxt;
            if (evolve) begin
                generation <= generation + GEN_WIDTH'(1);
            end
            if (wr_en) begin
                still <= 1'b0;
            end else if (evolve) begin
                still <= ~any_chg;
            end
        end
    end

endmodule
